// File: rtl/ysyx_2022040010_pipe_ctrl.sv
// Pipeline control for the in-order core.
// This file holds the per-stage valid cell and the top-level control unit.
// Stall requests are qualified by stage validity. A stall at stage k holds
// stages 0..k and inserts a bubble into stage k+1. An accepted branch
// redirect clears stages 1..BR_STAGE.

module ysyx_2022040010_pipe_stage (
  input  logic clk,
  input  logic rst,
  input  logic prev_valid,
  input  logic hold,
  input  logic bubble,
  input  logic kill,
  output logic valid
);

  // Redirect kill beats hold, so a redirect can clear stages that are being
  // held by a younger-side stall. Otherwise hold, then bubble, then advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         valid <= 1'b0;
    else if (kill)   valid <= 1'b0;
    else if (hold)   valid <= valid;
    else if (bubble) valid <= 1'b0;
    else             valid <= prev_valid;
  end

endmodule

module ysyx_2022040010_pipe_ctrl #(
  parameter int STAGES    = 5,
  parameter int BR_STAGE  = 2,
  parameter int PC_W      = 64,
  parameter int CNT_W     = 64,
  parameter int MAX_STALL = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] flush_o,
  output logic [STAGES-1:0] stage_valid,
  output logic              pc_load_o,
  output logic [PC_W-1:0]   pc_redirect_o,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_timeout
);

  localparam int RUN_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] req;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] bubble;
  logic              redirect_accept;
  logic [RUN_W-1:0]  run_cnt;

  // Requests from stages holding no instruction cannot stall anything.
  assign req = stallreq & vld;

  // Stall propagates from the oldest requesting stage down to IF.
  always_comb begin
    stall = '0;
    stall[STAGES-1] = req[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--)
      stall[i] = req[i] | stall[i+1];
  end

  // A redirect is taken only when the branch stage holds a live instruction
  // that is not itself frozen by an older-side stall.
  assign redirect_accept = redirect_valid & vld[BR_STAGE] & ~stall[BR_STAGE];

  // Kill stages 1..BR_STAGE on redirect; bubble the stage just past the stall.
  always_comb begin
    kill   = '0;
    bubble = '0;
    for (int i = 1; i < STAGES; i++) begin
      kill[i]   = redirect_accept & (i <= BR_STAGE);
      bubble[i] = stall[i-1] & ~stall[i];
    end
  end

  // One valid cell per stage. IF never holds or flushes its valid bit: it
  // refills with a fresh fetch every clock after reset.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_if
      ysyx_2022040010_pipe_stage u_stage (
        .clk        (clk),
        .rst        (rst),
        .prev_valid (1'b1),
        .hold       (1'b0),
        .bubble     (1'b0),
        .kill       (1'b0),
        .valid      (vld[g])
      );
    end else begin : g_body
      ysyx_2022040010_pipe_stage u_stage (
        .clk        (clk),
        .rst        (rst),
        .prev_valid (vld[g-1]),
        .hold       (stall[g]),
        .bubble     (bubble[g]),
        .kill       (kill[g]),
        .valid      (vld[g])
      );
    end
  end

  assign stall_o       = stall;
  assign flush_o       = kill | bubble;
  assign stage_valid   = vld;
  assign pc_load_o     = redirect_accept;
  assign pc_redirect_o = redirect_pc;

  // Performance counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (vld[STAGES-1] & ~stall[STAGES-1]) retire_cnt <= retire_cnt + 1'b1;
      if (stall[0])                         stall_cnt  <= stall_cnt + 1'b1;
    end
  end

  // Watchdog: saturating run length of front-end stall, sticky trip flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt       <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (run_cnt == RUN_W'(MAX_STALL)) stall_timeout <= 1'b1;
      if (!stall[0])                         run_cnt <= '0;
      else if (run_cnt != RUN_W'(MAX_STALL)) run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_2022040010_pipe_ctrl.sv
// Self-checking bench for the pipeline control unit: directed scenarios
// followed by random stimulus against a stage-level reference model.

module tb_ysyx_2022040010_pipe_ctrl;

  localparam int S  = 5;
  localparam int BR = 2;
  localparam int PW = 64;
  localparam int CW = 8;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [S-1:0]  stallreq;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic [S-1:0]  stall_o, flush_o, stage_valid;
  logic          pc_load_o;
  logic [PW-1:0] pc_redirect_o;
  logic [CW-1:0] retire_cnt, stall_cnt;
  logic          stall_timeout;

  ysyx_2022040010_pipe_ctrl #(
    .STAGES(S), .BR_STAGE(BR), .PC_W(PW), .CNT_W(CW), .MAX_STALL(MS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq       (stallreq),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .stage_valid    (stage_valid),
    .pc_load_o      (pc_load_o),
    .pc_redirect_o  (pc_redirect_o),
    .retire_cnt     (retire_cnt),
    .stall_cnt      (stall_cnt),
    .stall_timeout  (stall_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: valid bits per stage, plus counters kept as plain numbers.
  logic [S-1:0]  mv;
  logic [CW-1:0] m_ret, m_stl;
  int            m_run;
  bit            m_to;
  int            k;          // oldest stage with a live stall request, -1 if none
  bit            acc;
  logic [S-1:0]  e_stall, e_flush;

  task automatic model_reset();
    mv = '0; m_ret = '0; m_stl = '0; m_run = 0; m_to = 1'b0;
  endtask

  task automatic model_comb();
    k = -1;
    for (int i = 0; i < S; i++) if (stallreq[i] && mv[i]) k = i;
    acc = redirect_valid && mv[BR] && !(k >= BR);
    e_stall = '0; e_flush = '0;
    for (int i = 0; i < S; i++) begin
      e_stall[i] = (i <= k);
      if (i >= 1) e_flush[i] = (acc && i <= BR) || (k >= 0 && i == k + 1);
    end
  endtask

  task automatic model_commit();
    logic [S-1:0] nv;
    nv[0] = 1'b1;
    for (int i = 1; i < S; i++) begin
      if (acc && i <= BR)         nv[i] = 1'b0;
      else if (i <= k)            nv[i] = mv[i];
      else if (k >= 0 && i == k+1) nv[i] = 1'b0;
      else                        nv[i] = mv[i-1];
    end
    if (mv[S-1] && k < S - 1) m_ret = m_ret + 1'b1;
    if (k >= 0)               m_stl = m_stl + 1'b1;
    if (m_run == MS)          m_to  = 1'b1;
    m_run = (k >= 0) ? ((m_run + 1 > MS) ? MS : m_run + 1) : 0;
    mv = nv;
  endtask

  task automatic cmp();
    model_comb();
    chk("stall_o",       stall_o,       e_stall);
    chk("flush_o",       flush_o,       e_flush);
    chk("stage_valid",   stage_valid,   mv);
    chk("pc_load_o",     pc_load_o,     acc);
    chk("pc_redirect_o", pc_redirect_o, redirect_pc);
    chk("retire_cnt",    retire_cnt,    m_ret);
    chk("stall_cnt",     stall_cnt,     m_stl);
    chk("stall_timeout", stall_timeout, m_to);
  endtask

  task automatic drive(input logic [S-1:0] sr, input logic rv, input logic [PW-1:0] rpc);
    stallreq = sr; redirect_valid = rv; redirect_pc = rpc;
    #2;
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic step(input logic [S-1:0] sr, input logic rv, input logic [PW-1:0] rpc);
    drive(sr, rv, rpc);
    cmp();
    advance();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear with no clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    cmp();
    @(posedge clk);
    #1;
    cmp();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [S-1:0] sr;
    logic [S-1:0] expv;
    rst = 1'b1; stallreq = '0; redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    #3;
    cmp();
    @(posedge clk); #1;
    rst = 1'b0;

    // Requests from stages not yet valid are ignored.
    drive(5'b11110, 1'b0, '0);
    cmp();
    chk("invalid_req_stall", stall_o, 5'b00000);
    advance();
    chk("invalid_req_valid", stage_valid, 5'b00001);
    do_reset();

    // Fill from empty.
    for (int n = 1; n <= S; n++) begin
      step('0, 1'b0, '0);
      expv = S'((1 << n) - 1);
      chk("fill_valid", stage_valid, expv);
    end
    step('0, 1'b0, '0);
    chk("fill_retire", retire_cnt, 8'd1);

    // Load-use stall in ID.
    drive(5'b00010, 1'b0, '0);
    cmp();
    chk("lu_stall", stall_o, 5'b00011);
    chk("lu_flush", flush_o, 5'b00100);
    advance();
    chk("lu_valid", stage_valid, 5'b11011);
    for (int n = 0; n < 4; n++) step('0, 1'b0, '0);
    chk("refill1", stage_valid, 5'b11111);

    // Branch redirect on a full pipe.
    drive('0, 1'b1, 64'h8000_0100);
    cmp();
    chk("br_flush", flush_o, 5'b00110);
    chk("br_load", pc_load_o, 1'b1);
    advance();
    chk("br_valid", stage_valid, 5'b11001);
    chk("br_pc", pc_redirect_o, 64'h8000_0100);
    for (int n = 0; n < 5; n++) step('0, 1'b0, '0);

    // Redirect blocked by an older stall, then taken when it clears.
    drive(5'b01000, 1'b1, 64'h8000_0200);
    cmp();
    chk("blk_load", pc_load_o, 1'b0);
    chk("blk_stall", stall_o, 5'b01111);
    advance();
    drive('0, 1'b1, 64'h8000_0200);
    cmp();
    chk("blk_release_load", pc_load_o, 1'b1);
    advance();

    // Watchdog: WB stall held long enough to trip, then released.
    do_reset();
    for (int n = 0; n < S; n++) step('0, 1'b0, '0);
    for (int j = 1; j <= 6; j++) begin
      step(5'b10000, 1'b0, '0);
      if (j == MS)     chk("wd_not_yet", stall_timeout, 1'b0);
      if (j == MS + 1) chk("wd_trip", stall_timeout, 1'b1);
    end
    step('0, 1'b0, '0);
    step('0, 1'b0, '0);
    chk("wd_sticky", stall_timeout, 1'b1);
    do_reset();
    chk("wd_cleared", stall_timeout, 1'b0);

    // Random traffic, with occasional asynchronous resets.
    for (int n = 0; n < 700; n++) begin
      for (int b = 0; b < S; b++) sr[b] = ($urandom_range(0, 5) == 0);
      step(sr, ($urandom_range(0, 3) == 0), {$urandom, $urandom});
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
